// File: rtl/design_mux_pkg.sv
// Shared definitions for the design multiplexer: register map, CTRL layout, bus FSM states.
// Pure declarations; no latency or backpressure of its own.
package design_mux_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_COUNTER = 3'd1;
    localparam logic [2:0] REG_CUSTOM  = 3'd2;
    localparam logic [2:0] REG_OVR_EN  = 3'd3;
    localparam logic [2:0] REG_OVR_VAL = 3'd4;
    localparam logic [2:0] REG_OVR_OEB = 3'd5;
    localparam logic [2:0] REG_IO_IN   = 3'd6;
    localparam logic [2:0] REG_ID      = 3'd7;

    localparam int CTRL_OVR_ACT = 0;
    localparam int CTRL_RST_OVR = 1;
    localparam int CTRL_SEL_LSB = 2;
    localparam int CTRL_SEL_W   = 8;
    localparam int CTRL_BUSY    = 10;

    localparam int MAP_BIT = 23;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_BUSY = 2'd1,
        WB_ACK  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/design_mux_wb.sv
// Wishbone slave FSM and register file; ack two cycles after a request is sampled, write commits leaving ACK.
// One transfer at a time; dropping cyc/stb while busy aborts without ack or write.
module design_mux_wb
    import design_mux_pkg::*;
#(
    parameter int NUM_DESIGNS = 8,
    parameter int IO_W        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     adr,
    input  logic [31:0]     wr_data,
    input  logic            we,
    input  logic            cyc,
    input  logic            stb,
    output logic [31:0]     rd_data,
    output logic            ack,
    input  logic [IO_W-1:0] pad_val,
    input  logic            switch_busy,
    output logic            ovr_act,
    output logic            rst_ovr,
    output logic [7:0]      sel,
    output logic            ctrl_wr,
    output logic [7:0]      ctrl_sel,
    output logic [31:0]     custom,
    output logic [31:0]     ovr_en,
    output logic [31:0]     ovr_val,
    output logic [31:0]     ovr_oeb
);

    wb_state_t   state;
    logic [2:0]  idx;
    logic        mapped;
    logic        wr;
    logic [31:0] wdat;
    logic [31:0] counter;
    logic [31:0] rdata;
    logic        commit;
    logic        unused_adr;

    assign unused_adr = ^{adr[31:24], adr[22:5], adr[1:0]};

    assign commit   = (state == WB_ACK) && wr && mapped;
    assign ctrl_wr  = commit && (idx == REG_CTRL);
    assign ctrl_sel = wdat[CTRL_SEL_LSB +: CTRL_SEL_W];

    always_comb begin
        rdata = '1;
        if (mapped) begin
            case (idx)
                REG_CTRL: begin
                    rdata = '0;
                    rdata[CTRL_OVR_ACT]                  = ovr_act;
                    rdata[CTRL_RST_OVR]                  = rst_ovr;
                    rdata[CTRL_SEL_LSB +: CTRL_SEL_W]    = sel;
                    rdata[CTRL_BUSY]                     = switch_busy;
                end
                REG_COUNTER: rdata = counter;
                REG_CUSTOM:  rdata = custom;
                REG_OVR_EN:  rdata = ovr_en;
                REG_OVR_VAL: rdata = ovr_val;
                REG_OVR_OEB: rdata = ovr_oeb;
                REG_IO_IN:   rdata = 32'(pad_val);
                REG_ID:      rdata = {16'(NUM_DESIGNS), 16'(IO_W)};
                default:     rdata = '1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WB_IDLE;
            ack     <= 1'b0;
            rd_data <= '0;
            idx     <= '0;
            mapped  <= 1'b0;
            wr      <= 1'b0;
            wdat    <= '0;
            counter <= '0;
            ovr_act <= 1'b0;
            rst_ovr <= 1'b1;
            sel     <= '0;
            custom  <= '0;
            ovr_en  <= '0;
            ovr_val <= '0;
            ovr_oeb <= '0;
        end else begin
            counter <= counter + 32'd1;
            ack     <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (cyc && stb) begin
                        state  <= WB_BUSY;
                        idx    <= adr[4:2];
                        mapped <= adr[MAP_BIT];
                        wr     <= we;
                        wdat   <= wr_data;
                    end
                end
                WB_BUSY: begin
                    if (cyc && stb) begin
                        state   <= WB_ACK;
                        ack     <= 1'b1;
                        rd_data <= rdata;
                    end else begin
                        state <= WB_IDLE;
                    end
                end
                WB_ACK: begin
                    state <= WB_IDLE;
                    if (commit) begin
                        // A counter write lands after the increment above, so it wins.
                        case (idx)
                            REG_CTRL: begin
                                ovr_act <= wdat[CTRL_OVR_ACT];
                                rst_ovr <= wdat[CTRL_RST_OVR];
                                sel     <= wdat[CTRL_SEL_LSB +: CTRL_SEL_W];
                            end
                            REG_COUNTER: counter <= wdat;
                            REG_CUSTOM:  custom  <= wdat;
                            REG_OVR_EN:  ovr_en  <= wdat;
                            REG_OVR_VAL: ovr_val <= wdat;
                            REG_OVR_OEB: ovr_oeb <= wdat;
                            default: ;
                        endcase
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/design_mux_gen.sv
// Selects one of NUM_DESIGNS user designs onto the pads, with a timed reset/tri-state hold on every switch.
// Pad paths are combinational from registered state; register access goes through design_mux_wb.
module design_mux_gen
    import design_mux_pkg::*;
#(
    parameter int          NUM_DESIGNS = 8,
    parameter int          IO_W        = 32,
    parameter int          SW_HOLD     = 16,
    parameter logic [31:0] IDLE_PAT    = 32'h0228A64C
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [IO_W+4:0]             io_in,
    output logic [IO_W+4:0]             io_out,
    output logic [IO_W+4:0]             io_oeb,
    input  logic [31:0]                 wbs_adr_i,
    input  logic [31:0]                 wbs_dat_i,
    input  logic                        wbs_we_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    output logic [31:0]                 wbs_dat_o,
    output logic                        wbs_ack_o,
    input  logic [NUM_DESIGNS*IO_W-1:0] des_do,
    input  logic [NUM_DESIGNS*IO_W-1:0] des_oeb,
    output logic [NUM_DESIGNS-1:0]      des_rst_n,
    output logic [31:0]                 custom_settings
);

    localparam logic [IO_W-1:0] IDLE_LO = IDLE_PAT[IO_W-1:0];

    logic            ovr_act;
    logic            rst_ovr;
    logic [7:0]      reg_sel;
    logic            ctrl_wr;
    logic [7:0]      ctrl_sel;
    logic [31:0]     ovr_en;
    logic [31:0]     ovr_val;
    logic [31:0]     ovr_oeb;
    logic [7:0]      active_sel;
    logic [7:0]      pend_sel;
    logic            switch_busy;
    logic [7:0]      hold_cnt;
    logic            rst_base;
    logic [IO_W-1:0] src_do;
    logic [IO_W-1:0] src_oeb;
    logic [IO_W-1:0] pad_do;
    logic [IO_W-1:0] pad_oeb;
    logic            unused_sig;

    assign unused_sig = ^{io_in[4:1], reg_sel};

    design_mux_wb #(
        .NUM_DESIGNS (NUM_DESIGNS),
        .IO_W        (IO_W)
    ) u_wb (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .adr         (wbs_adr_i),
        .wr_data     (wbs_dat_i),
        .we          (wbs_we_i),
        .cyc         (wbs_cyc_i),
        .stb         (wbs_stb_i),
        .rd_data     (wbs_dat_o),
        .ack         (wbs_ack_o),
        .pad_val     (io_in[IO_W+4:5]),
        .switch_busy (switch_busy),
        .ovr_act     (ovr_act),
        .rst_ovr     (rst_ovr),
        .sel         (reg_sel),
        .ctrl_wr     (ctrl_wr),
        .ctrl_sel    (ctrl_sel),
        .custom      (custom_settings),
        .ovr_en      (ovr_en),
        .ovr_val     (ovr_val),
        .ovr_oeb     (ovr_oeb)
    );

    // Hold restarts only when the newest sel differs from the one already being switched to.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            active_sel  <= '0;
            pend_sel    <= '0;
            switch_busy <= 1'b0;
            hold_cnt    <= '0;
        end else if (ctrl_wr && (switch_busy ? (ctrl_sel != pend_sel) : (ctrl_sel != active_sel))) begin
            switch_busy <= 1'b1;
            pend_sel    <= ctrl_sel;
            hold_cnt    <= 8'(SW_HOLD);
        end else if (switch_busy) begin
            if (hold_cnt == 8'd1) begin
                switch_busy <= 1'b0;
                active_sel  <= pend_sel;
            end else begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

    assign rst_base = ovr_act ? rst_ovr : io_in[0];

    always_comb begin
        src_do    = IDLE_LO;
        src_oeb   = '0;
        des_rst_n = '0;
        for (int i = 0; i < NUM_DESIGNS; i++) begin
            if (active_sel == 8'(i)) begin
                src_do       = des_do[i*IO_W +: IO_W];
                src_oeb      = des_oeb[i*IO_W +: IO_W];
                des_rst_n[i] = rst_base && !switch_busy;
            end
        end
        pad_do  = switch_busy ? '0 : src_do;
        pad_oeb = switch_busy ? '1 : src_oeb;
        for (int b = 0; b < IO_W; b++) begin
            if (ovr_en[b]) begin
                pad_do[b]  = ovr_val[b];
                pad_oeb[b] = ovr_oeb[b];
            end
        end
    end

    assign io_out = {pad_do, 5'b00000};
    assign io_oeb = {pad_oeb, 5'b11111};

endmodule

// File: tb/tb_design_mux_gen.sv
// Directed bench for design_mux_gen: bus transfers push expected read data to a scoreboard
// that a separate negedge monitor pops on every ack.
module tb_design_mux_gen;

    localparam int ND = 8;
    localparam int IW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [IW+4:0]     io_in;
    logic [IW+4:0]     io_out;
    logic [IW+4:0]     io_oeb;
    logic [31:0]       adr;
    logic [31:0]       wdat;
    logic              we;
    logic              cyc;
    logic              stb;
    logic [31:0]       rdat;
    logic              ack;
    logic [ND*IW-1:0]  des_do;
    logic [ND*IW-1:0]  des_oeb;
    logic [ND-1:0]     des_rst_n;
    logic [31:0]       custom;

    always #5 clk = ~clk;

    design_mux_gen dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .io_in           (io_in),
        .io_out          (io_out),
        .io_oeb          (io_oeb),
        .wbs_adr_i       (adr),
        .wbs_dat_i       (wdat),
        .wbs_we_i        (we),
        .wbs_cyc_i       (cyc),
        .wbs_stb_i       (stb),
        .wbs_dat_o       (rdat),
        .wbs_ack_o       (ack),
        .des_do          (des_do),
        .des_oeb         (des_oeb),
        .des_rst_n       (des_rst_n),
        .custom_settings (custom)
    );

    int          total = 0;
    int          bad = 0;
    int          ack_cnt = 0;
    logic        sb_chk[$];
    logic [31:0] sb_dat[$];
    string       sb_name[$];
    logic        watch2 = 1'b0;
    logic        saw2 = 1'b0;

    function automatic logic [31:0] slice_do(int i);
        return 32'h11111111 * (i + 1);
    endfunction

    function automatic logic [31:0] slice_oeb(int i);
        return 32'h0F0F0000 | 32'(i);
    endfunction

    // Scoreboard monitor: every ack must match a queued transfer.
    always @(negedge clk) begin
        logic        c;
        logic [31:0] d;
        string       n;
        if (ack) begin
            ack_cnt++;
            if (sb_chk.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack=1 required no ack");
            end else begin
                c = sb_chk.pop_front();
                d = sb_dat.pop_front();
                n = sb_name.pop_front();
                if (c) begin
                    total++;
                    if (rdat !== d) begin
                        bad++;
                        $display("FAIL %s: got %h required %h", n, rdat, d);
                    end
                end
            end
        end
        if (watch2 && des_rst_n[2]) saw2 = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that leaves ACK.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic chk, input logic [31:0] e, input string name);
        int   n;
        logic got;
        sb_chk.push_back(chk);
        sb_dat.push_back(e);
        sb_name.push_back(name);
        adr = a; wdat = d; we = w; cyc = 1'b1; stb = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ack) got = 1'b1;
        end
        check({name, "_ack_latency"}, 64'(n), 64'd2);
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d, input string name);
        xfer(32'h0080_0000 | {27'd0, idx, 2'b00}, d, 1'b1, 1'b0, 32'd0, name);
    endtask

    task automatic rd(input logic [2:0] idx, input logic [31:0] e, input string name);
        xfer(32'h0080_0000 | {27'd0, idx, 2'b00}, 32'd0, 1'b0, 1'b1, e, name);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts cycles in the forced-reset, tri-stated state; ends on a negedge.
    task automatic count_switch(output int c);
        c = 0;
        @(negedge clk);
        while (c < 40 && des_rst_n == '0 && io_oeb[IW+4:5] == '1 && io_out[IW+4:5] == '0) begin
            c++;
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        int a0;
        rst = 1'b1;
        adr = '0; wdat = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        io_in = {32'hC0FFEE11, 4'b0000, 1'b1};
        for (int i = 0; i < ND; i++) begin
            des_do[i*IW +: IW]  = slice_do(i);
            des_oeb[i*IW +: IW] = slice_oeb(i);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_dat_o", 64'(rdat), 64'd0);
        check("rst_custom", 64'(custom), 64'd0);
        check("rst_des_rst_n", 64'(des_rst_n), 64'h01);
        check("rst_pads_out", 64'(io_out[IW+4:5]), 64'(slice_do(0)));
        check("rst_pads_oeb", 64'(io_oeb[IW+4:5]), 64'(slice_oeb(0)));
        check("fixed_low_out", 64'(io_out[4:0]), 64'h00);
        check("fixed_low_oeb", 64'(io_oeb[4:0]), 64'h1F);
        @(posedge clk);
        #1;
        rd(3'd0, 32'h0000_0002, "rst_ctrl_read");
        rd(3'd7, 32'h0008_0020, "id_read");
        rd(3'd6, 32'hC0FFEE11, "io_in_read");
        wr(3'd7, 32'h1234_5678, "id_write");
        rd(3'd7, 32'h0008_0020, "id_after_write");
        xfer(32'h0000_0004, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, "unmapped_read");
        xfer(32'h0000_0008, 32'h77, 1'b1, 1'b0, 32'd0, "unmapped_write");
        check("unmapped_write_ignored", 64'(custom), 64'd0);

        wr(3'd2, 32'h1234_5678, "custom_write");
        check("custom_out", 64'(custom), 64'h1234_5678);
        rd(3'd2, 32'h1234_5678, "custom_read");

        // Switch to design 3 with reset override released
        wr(3'd0, 32'h0000_000F, "ctrl_sel3");
        count_switch(c);
        check("sel3_hold_cycles", 64'(c), 64'd16);
        check("sel3_des_rst_n", 64'(des_rst_n), 64'h08);
        check("sel3_pads_out", 64'(io_out[IW+4:5]), 64'(slice_do(3)));
        check("sel3_pads_oeb", 64'(io_oeb[IW+4:5]), 64'(slice_oeb(3)));
        @(posedge clk);
        #1;

        // Counter load wins over increment, then wraps
        wr(3'd1, 32'hFFFF_FFFE, "counter_write");
        idle(3);
        rd(3'd1, 32'h0000_0002, "counter_wrap_read");

        // Out-of-range selection drives the idle pattern
        wr(3'd0, 32'h0000_0027, "ctrl_sel9");
        count_switch(c);
        check("sel9_hold_cycles", 64'(c), 64'd16);
        check("sel9_pads_out", 64'(io_out[IW+4:5]), 64'h0228_A64C);
        check("sel9_pads_oeb", 64'(io_oeb[IW+4:5]), 64'd0);
        check("sel9_des_rst_n", 64'(des_rst_n), 64'h00);
        @(posedge clk);
        #1;
        rd(3'd0, 32'h0000_0027, "ctrl_sel9_read");

        // Per-pad override holds through a switch
        wr(3'd3, 32'h1, "ovr_en_write");
        wr(3'd4, 32'h1, "ovr_val_write");
        wr(3'd5, 32'h0, "ovr_oeb_write");
        wr(3'd0, 32'h0000_0007, "ctrl_sel1");
        @(negedge clk);
        check("ovr_pad5_out", 64'(io_out[5]), 64'd1);
        check("ovr_pad5_oeb", 64'(io_oeb[5]), 64'd0);
        check("ovr_other_oeb", 64'(io_oeb[IW+4:6]), 64'h7FFF_FFFF);
        check("ovr_other_out", 64'(io_out[IW+4:6]), 64'd0);
        @(posedge clk);
        #1;
        rd(3'd0, 32'h0000_0407, "ctrl_busy_read");
        idle(20);
        wr(3'd3, 32'h0, "ovr_en_clear");
        check("sel1_des_rst_n", 64'(des_rst_n), 64'h02);

        // Restarted hold: design 2 is never released
        watch2 = 1'b1;
        wr(3'd0, 32'h0000_000B, "ctrl_sel2");
        idle(10);
        wr(3'd0, 32'h0000_0017, "ctrl_sel5");
        count_switch(c);
        check("sel5_hold_cycles", 64'(c), 64'd16);
        check("sel5_des_rst_n", 64'(des_rst_n), 64'h20);
        check("sel5_pads_out", 64'(io_out[IW+4:5]), 64'(slice_do(5)));
        idle(3);
        watch2 = 1'b0;
        check("sel2_never_released", 64'(saw2), 64'd0);

        // Abort in BUSY: no ack, no write
        a0 = ack_cnt;
        adr = 32'h0080_0008; wdat = 32'h0000_0BAD; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        idle(4);
        check("abort_no_ack", 64'(ack_cnt - a0), 64'd0);
        check("abort_no_write", 64'(custom), 64'h1234_5678);

        // Reset while BUSY with the request still held
        a0 = ack_cnt;
        adr = 32'h0080_0008; wdat = 32'h0000_0005; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        idle(4);
        check("rst_busy_no_ack", 64'(ack_cnt - a0), 64'd0);
        check("rst_busy_custom", 64'(custom), 64'd0);
        check("rst_busy_des_rst_n", 64'(des_rst_n), 64'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/design_mux_gen.md
DESIGN_MUX_GEN -- requirements
Module: design_mux_gen

Interface
REQ-001 The block SHALL use parameter NUM_DESIGNS, default 8: number of selectable designs, 2..32.
REQ-002 The block SHALL use parameter IO_W, default 32: design-owned pad count, 1..32.
REQ-003 The block SHALL use parameter SW_HOLD, default 16: cycles of forced reset and tri-state on a design switch, 1..255.
REQ-004 The block SHALL use parameter IDLE_PAT, default 32'h0228A64C: value driven on pads when the selection is out of range.
REQ-005 Ports SHALL be: wb_clk_i  in  1  sole clock; wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 Ports SHALL be: io_in  in  IO_W+5  pads; io_out  out  IO_W+5; io_oeb  out  IO_W+5, with bits [4:0] fixed out=0, oeb=1.
REQ-007 Ports SHALL be: wbs_adr_i, wbs_dat_i  in  32; wbs_we_i, wbs_cyc_i, wbs_stb_i  in  1; wbs_dat_o  out  32; wbs_ack_o  out  1.
REQ-008 Ports SHALL be: des_do, des_oeb  in  NUM_DESIGNS*IO_W, design i in slice [i*IO_W +: IO_W]; des_rst_n  out  NUM_DESIGNS, active-low per-design reset; custom_settings  out  32.

Function
REQ-009 Wishbone FSM SHALL have states IDLE, BUSY, ACK: IDLE->BUSY on cyc&stb; BUSY->ACK; ACK->IDLE unconditionally; wbs_ack_o=1 only in ACK, giving ack 2 cycles after the request is first sampled.
REQ-010 Dropping cyc or stb in BUSY SHALL abort to IDLE with no ack and no register write.
REQ-011 Writes SHALL commit at the edge leaving ACK; wbs_dat_o SHALL be registered and valid during ACK.
REQ-012 With adr[23]=1, word index adr[4:2] SHALL select: 0 CTRL, 1 COUNTER, 2 CUSTOM, 3 OVR_EN, 4 OVR_VAL, 5 OVR_OEB, 6 IO_IN (RO), 7 ID (RO).
REQ-013 With adr[23]=0, reads SHALL return 32'hFFFFFFFF, writes SHALL be ignored, and ack SHALL still be given.
REQ-014 CTRL SHALL be: [0] ovr_act, [1] rst_ovr, [9:2] sel; reads SHALL also return [10] switch_busy; other bits read 0.
REQ-015 COUNTER SHALL increment every cycle, wrapping at 2^32; a write SHALL load the written value, overriding that cycle's increment.
REQ-016 IO_IN SHALL read io_in[IO_W+4:5], zero-extended; ID SHALL read {16'(NUM_DESIGNS), 16'(IO_W)}; writes to either SHALL be ignored.
REQ-017 rst_base SHALL be rst_ovr when ovr_act=1, else io_in[0].
REQ-018 Writing CTRL with a sel differing from the active selection SHALL start a switch: switch_busy=1 and a counter loaded with SW_HOLD.
REQ-019 During a switch, all des_rst_n SHALL be 0 and all design pads SHALL have oeb=1, out=0; the new sel SHALL become active after SW_HOLD cycles.
REQ-020 A CTRL write with a different sel during a switch SHALL restart the hold with the newest sel; a same-sel write SHALL NOT restart the hold.
REQ-021 Outside a switch, des_rst_n[i] SHALL be rst_base for i=active sel, and 0 for every other design.
REQ-022 Pad source SHALL be design sel's des_do/des_oeb when sel<NUM_DESIGNS; otherwise out=IDLE_PAT[IO_W-1:0] with oeb=0.
REQ-023 Per pad bit b with OVR_EN[b]=1, out SHALL be OVR_VAL[b] and oeb SHALL be OVR_OEB[b], including during a switch.
REQ-024 Pad output paths SHALL be combinational from registered state and design inputs, with no added latency.

Reset
REQ-025 wb_rst_i SHALL set: FSM IDLE, wbs_ack_o=0, wbs_dat_o=0, ovr_act=0, rst_ovr=1, sel=0 active, switch_busy=0, COUNTER=0, custom_settings=0, OVR_EN/OVR_VAL/OVR_OEB=0.
REQ-026 Reset asserted mid-transaction SHALL drop ack on the next edge and SHALL discard the pending write.

Structure
REQ-027 Package design_mux_pkg SHALL hold the register index constants, the Wishbone FSM state type, and the CTRL field positions.
REQ-028 The Wishbone FSM and register file SHALL be one sub-module, design_mux_wb; pad muxing and switch sequencing SHALL stay in the top.

Verification
REQ-029 Bench SHALL check: write CTRL sel=3, ovr_act=1, rst_ovr=1 -> ack exactly 2 cycles after stb; switch_busy=1 for 16 cycles; then des_rst_n=8'b0000_1000 and pads = des_do slice 3.
REQ-030 Bench SHALL check: sel=9 with NUM_DESIGNS=8 -> io_out[36:5]=32'h0228A64C, io_oeb[36:5]=0.
REQ-031 Bench SHALL check: OVR_EN=1, OVR_VAL=1, OVR_OEB=0 during a switch -> io_out[5]=1, io_oeb[5]=0, all other design pads oeb=1.
REQ-032 Bench SHALL check: write sel=2, then sel=5 after 10 cycles -> hold restarts; sel 5 active 16 cycles after the second ack; sel 2 never released.
REQ-033 Bench SHALL check: COUNTER write 32'hFFFFFFFE, then read 3 cycles later -> wrapped value, exact per REQ-011 and REQ-015 timing.
REQ-034 Bench SHALL check: wb_rst_i asserted in BUSY of a CUSTOM write of 32'h5 -> no ack, and custom_settings=0.
